// File: rtl/io_bus_ctrl.sv
// Peripheral IO bus master: turns single CPU load/store requests into chip-select/strobe
// cycles on the shared tristate data bus. Optional macro IO_BUS_ERR_EN enables rsp_err reporting.
module io_bus_ctrl #(
    parameter int NUM_DEV  = 8,
    parameter int WAIT_CYC = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    input  logic               req_we,
    input  logic [31:0]        req_addr,
    input  logic [31:0]        req_wdata,
    output logic               req_ready,
    output logic [31:0]        rsp_rdata,
    output logic               rsp_err,
    inout  wire  [31:0]        data_io,
    output logic [NUM_DEV-1:0] cs_en,
    output logic               wt_en,
    output logic               rd_en,
    output logic [3:0]         addr_out
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    localparam int               CNT_W     = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(WAIT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
    localparam logic [4:0]       NUM_DEV_W = 5'(NUM_DEV);

`ifdef IO_BUS_ERR_EN
    localparam logic [31:0] BAD_DEV_RDATA = 32'h0000_0000;
`else
    localparam logic [31:0] BAD_DEV_RDATA = 32'hFFFF_FFFF;
`endif

    logic [1:0]         state_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               we_r;
    logic [31:0]        wdata_r;
    logic               drive_r;
    logic [NUM_DEV-1:0] cs_en_r;
    logic               wt_en_r;
    logic               rd_en_r;
    logic [3:0]         addr_out_r;
    logic               req_ready_r;
    logic [31:0]        rsp_rdata_r;

    logic [3:0]         dev_s;
    logic               dev_ok_s;
    logic [NUM_DEV-1:0] dev_onehot_s;
    logic               unused_addr_s;

    function automatic logic [NUM_DEV-1:0] dev_decode(input logic [3:0] dev);
        logic [NUM_DEV-1:0] oh;
        oh = {NUM_DEV{1'b0}};
        for (int i = 0; i < NUM_DEV; i++) begin
            if (dev == i[3:0]) begin
                oh[i] = 1'b1;
            end else begin
                oh[i] = 1'b0;
            end
        end
        return oh;
    endfunction

    // Device index decode from the live request; only consumed while IDLE.
    always_comb begin
        dev_s        = req_addr[9:6];
        dev_ok_s     = ({1'b0, dev_s} < NUM_DEV_W);
        dev_onehot_s = dev_decode(dev_s);
    end

    assign unused_addr_s = ^{req_addr[31:10], req_addr[1:0]};

    // Bus cycle sequencer; every bus-facing output is a flop so strobes are glitch-free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            cnt_r       <= CNT_ZERO;
            we_r        <= 1'b0;
            wdata_r     <= 32'h0000_0000;
            drive_r     <= 1'b0;
            cs_en_r     <= {NUM_DEV{1'b0}};
            wt_en_r     <= 1'b0;
            rd_en_r     <= 1'b0;
            addr_out_r  <= 4'hF;
            req_ready_r <= 1'b0;
            rsp_rdata_r <= 32'h0000_0000;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    req_ready_r <= 1'b0;
                    if (req_valid) begin
                        we_r    <= req_we;
                        wdata_r <= req_wdata;
                        if (dev_ok_s) begin
                            state_r    <= ST_SETUP;
                            cs_en_r    <= dev_onehot_s;
                            addr_out_r <= req_addr[5:2];
                            wt_en_r    <= req_we;
                            rd_en_r    <= ~req_we;
                            drive_r    <= req_we;
                        end else begin
                            // Unmapped device: no strobes at all, complete right away.
                            state_r     <= ST_DONE;
                            req_ready_r <= 1'b1;
                            rsp_rdata_r <= BAD_DEV_RDATA;
                        end
                    end
                end
                ST_SETUP: begin
                    state_r <= ST_ACCESS;
                    cnt_r   <= CNT_LOAD;
                end
                ST_ACCESS: begin
                    if (cnt_r == CNT_ZERO) begin
                        if (!we_r) begin
                            rsp_rdata_r <= data_io;
                        end
                        state_r     <= ST_DONE;
                        cs_en_r     <= {NUM_DEV{1'b0}};
                        wt_en_r     <= 1'b0;
                        rd_en_r     <= 1'b0;
                        drive_r     <= 1'b0;
                        addr_out_r  <= 4'hF;
                        req_ready_r <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                ST_DONE: begin
                    state_r     <= ST_IDLE;
                    req_ready_r <= 1'b0;
                end
                default: begin
                    state_r     <= ST_IDLE;
                    cs_en_r     <= {NUM_DEV{1'b0}};
                    wt_en_r     <= 1'b0;
                    rd_en_r     <= 1'b0;
                    drive_r     <= 1'b0;
                    addr_out_r  <= 4'hF;
                    req_ready_r <= 1'b0;
                end
            endcase
        end
    end

`ifdef IO_BUS_ERR_EN
    logic rsp_err_r;

    // Error flag is set only by the unmapped-device path and cleared by every real access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_err_r <= 1'b0;
        end else begin
            if ((state_r == ST_IDLE) && req_valid && !dev_ok_s) begin
                rsp_err_r <= 1'b1;
            end else if ((state_r == ST_ACCESS) && (cnt_r == CNT_ZERO)) begin
                rsp_err_r <= 1'b0;
            end else begin
                rsp_err_r <= rsp_err_r;
            end
        end
    end

    assign rsp_err = rsp_err_r;
`else
    assign rsp_err = 1'b0;
`endif

    // drive_r is only set for writes, so the bus is released whenever rd_en is high.
    assign data_io   = drive_r ? wdata_r : {32{1'bz}};
    assign cs_en     = cs_en_r;
    assign wt_en     = wt_en_r;
    assign rd_en     = rd_en_r;
    assign addr_out  = addr_out_r;
    assign req_ready = req_ready_r;
    assign rsp_rdata = rsp_rdata_r;

endmodule

// File: tb/tb_io_bus_ctrl.sv
// Directed scoreboard bench for io_bus_ctrl: one instance with WAIT_CYC=1, one with WAIT_CYC=4.
module tb_io_bus_ctrl;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        sel;
    logic        probe_en;
    logic [31:0] model_val;

    logic        req_valid1, req_valid4;
    logic        ready1, ready4, err1, err4, wt1, wt4, rd1, rd4;
    logic [31:0] rdata1, rdata4;
    logic [7:0]  cs1, cs4;
    logic [3:0]  ad1, ad4;
    wire  [31:0] bus1;
    wire  [31:0] bus4;

    logic        o_ready, o_err, o_wt, o_rd;
    logic [31:0] o_rdata, o_data;
    logic [7:0]  o_cs;
    logic [3:0]  o_ad;

    int   n_vec;
    int   n_err;
    rsp_t sb[$];
    logic [31:0] rd1_last;
    logic [31:0] rd4_last;
    logic [31:0] bad_rdata;
    logic        bad_err;

    assign req_valid1 = req_valid & ~sel;
    assign req_valid4 = req_valid & sel;

    // Peripheral model: device 3 returns model_val on reads; the probe pulls the bus to zero.
    assign bus1 = probe_en ? 32'h0000_0000 :
                  (((cs1 & 8'h08) != 8'h00) && !wt1) ? model_val : {32{1'bz}};
    assign bus4 = probe_en ? 32'h0000_0000 :
                  (((cs4 & 8'h08) != 8'h00) && !wt4) ? model_val : {32{1'bz}};

    io_bus_ctrl #(.NUM_DEV(8), .WAIT_CYC(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid1), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(ready1),
        .rsp_rdata(rdata1), .rsp_err(err1), .data_io(bus1), .cs_en(cs1),
        .wt_en(wt1), .rd_en(rd1), .addr_out(ad1)
    );

    io_bus_ctrl #(.NUM_DEV(8), .WAIT_CYC(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid4), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(ready4),
        .rsp_rdata(rdata4), .rsp_err(err4), .data_io(bus4), .cs_en(cs4),
        .wt_en(wt4), .rd_en(rd4), .addr_out(ad4)
    );

    always_comb begin
        if (sel) begin
            o_ready = ready4; o_err = err4; o_wt = wt4; o_rd = rd4;
            o_rdata = rdata4; o_data = bus4; o_cs = cs4; o_ad = ad4;
        end else begin
            o_ready = ready1; o_err = err1; o_wt = wt1; o_rd = rd1;
            o_rdata = rdata1; o_data = bus1; o_cs = cs1; o_ad = ad1;
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Idle bus: strobes low, address parked, controller not driving (probe reads back zero).
    task automatic chk_idle(input string tag);
        chk({tag, ":cs"}, 32'(o_cs), 32'h0);
        chk({tag, ":wt"}, 32'(o_wt), 32'h0);
        chk({tag, ":rd"}, 32'(o_rd), 32'h0);
        chk({tag, ":addr"}, 32'(o_ad), 32'hF);
        probe_en = 1'b1;
        #1;
        chk({tag, ":hiz"}, o_data, 32'h0);
        probe_en = 1'b0;
    endtask

    task automatic txn(input string tag, input bit use4, input bit we, input logic [31:0] addr,
                       input logic [31:0] wdata, input bit drop, input bit vary,
                       input logic [31:0] base, input int exp_lat, input logic [7:0] exp_cs,
                       input logic [3:0] exp_reg, input logic [31:0] exp_rdata,
                       input logic exp_err);
        rsp_t rsp;
        bit   done;
        sel       = use4;
        model_val = vary ? 32'h1111_0000 : base;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_valid = 1'b1;
        sb.push_back('{rdata: exp_rdata, err: exp_err});
        done = 1'b0;
        for (int k = 1; k <= exp_lat + 3 && !done; k++) begin
            @(negedge clk);
            if (drop) req_valid = 1'b0;
            if (o_ready) begin
                chk({tag, ":lat"}, 32'(k), 32'(exp_lat));
                chk_idle({tag, ":done"});
                rsp = sb.pop_front();
                chk({tag, ":rdata"}, o_rdata, rsp.rdata);
                chk({tag, ":err"}, 32'(o_err), 32'(rsp.err));
                done = 1'b1;
            end else if (k < exp_lat) begin
                chk({tag, ":cs"}, 32'(o_cs), 32'(exp_cs));
                chk({tag, ":addr"}, 32'(o_ad), 32'(exp_reg));
                chk({tag, ":wt"}, 32'(o_wt), 32'(we));
                chk({tag, ":rd"}, 32'(o_rd), 32'(!we));
                chk({tag, ":data"}, o_data, we ? wdata : model_val);
                if (vary) model_val = 32'h1111_0000 + 32'(k);
            end
        end
        if (!done) begin
            chk({tag, ":timeout"}, 32'(done), 32'h1);
            void'(sb.pop_front());
        end
        req_valid = 1'b0;
        @(negedge clk);
        chk({tag, ":gap_cs"}, 32'(o_cs), 32'h0);
        chk({tag, ":gap_ready"}, 32'(o_ready), 32'h0);
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0; sel = 1'b0;
        probe_en = 1'b0; model_val = 32'h0;
        rd1_last = 32'h0; rd4_last = 32'h0;
`ifdef IO_BUS_ERR_EN
        bad_rdata = 32'h0000_0000; bad_err = 1'b1;
`else
        bad_rdata = 32'hFFFF_FFFF; bad_err = 1'b0;
`endif
        repeat (2) @(negedge clk);
        chk_idle("rst");
        chk("rst:ready", 32'(o_ready), 32'h0);
        chk("rst:rdata", o_rdata, 32'h0);
        chk("rst:err", 32'(o_err), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        chk_idle("idle");

        // Write dev1 reg2; req_valid dropped after acceptance must not matter.
        txn("wr_dev1", 1'b0, 1'b1, 32'h0000_0048, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0,
            3, 8'h02, 4'h2, rd1_last, 1'b0);

        // Read dev3 reg5; wdata non-zero so any controller drive would corrupt the bus.
        txn("rd_dev3", 1'b0, 1'b0, 32'h0000_00D4, 32'hA5A5_0F0F, 1'b0, 1'b0, 32'h1234_5678,
            3, 8'h08, 4'h5, 32'h1234_5678, 1'b0);
        rd1_last = 32'h1234_5678;

        // Unmapped device 12 completes after one cycle without strobes.
        txn("bad_dev", 1'b0, 1'b0, 32'h0000_0300, 32'h0, 1'b0, 1'b0, 32'h0,
            1, 8'h00, 4'hF, bad_rdata, bad_err);
        rd1_last = bad_rdata;

        // Reset during the ACCESS cycle of a write.
        sel = 1'b0; req_we = 1'b1; req_addr = 32'h0000_0048; req_wdata = 32'hCAFE_F00D;
        req_valid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("abort:pre_wt", 32'(o_wt), 32'h1);
        chk("abort:pre_data", o_data, 32'hCAFE_F00D);
        #2;
        rst_n = 1'b0; req_valid = 1'b0; probe_en = 1'b1;
        #1;
        chk("abort:cs", 32'(o_cs), 32'h0);
        chk("abort:wt", 32'(o_wt), 32'h0);
        chk("abort:addr", 32'(o_ad), 32'hF);
        chk("abort:hiz", o_data, 32'h0);
        chk("abort:rdata", o_rdata, 32'h0);
        probe_en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("abort:no_ready", 32'(o_ready), 32'h0);
        end
        rst_n = 1'b1; rd1_last = 32'h0;
        @(negedge clk);
        chk("abort:post_ready", 32'(o_ready), 32'h0);

        txn("rd_after_rst", 1'b0, 1'b0, 32'h0000_00C0, 32'h5555_AAAA, 1'b0, 1'b0,
            32'h0BAD_CAFE, 3, 8'h08, 4'h0, 32'h0BAD_CAFE, 1'b0);
        rd1_last = 32'h0BAD_CAFE;

        // Back-to-back writes: dev0 reg1 then dev7 reg3.
        txn("b2b_dev0", 1'b0, 1'b1, 32'h0000_0004, 32'h0000_0001, 1'b0, 1'b0, 32'h0,
            3, 8'h01, 4'h1, rd1_last, 1'b0);
        txn("b2b_dev7", 1'b0, 1'b1, 32'h0000_01CC, 32'h8000_0007, 1'b0, 1'b0, 32'h0,
            3, 8'h80, 4'h3, rd1_last, 1'b0);

        // WAIT_CYC=4 read with changing peripheral data; only the final ACCESS value counts.
        txn("rd_wait4", 1'b1, 1'b0, 32'h0000_00D4, 32'hA5A5_0F0F, 1'b0, 1'b1, 32'h0,
            6, 8'h08, 4'h5, 32'h1111_0005, 1'b0);
        rd4_last = 32'h1111_0005;
        txn("wr_wait4", 1'b1, 1'b1, 32'h0000_0048, 32'h0F0F_1234, 1'b0, 1'b0, 32'h0,
            6, 8'h02, 4'h2, rd4_last, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
